// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

  localparam logic [31:0] ARB_ERR_DATA = 32'hdeadbeaf;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, memory and error signals of the memory port arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req_valid;
  logic          if_req_ready;
  logic [AW-1:0] if_addr;
  logic          if_resp_valid;
  logic [DW-1:0] if_rdata;

  logic          ls_req_valid;
  logic          ls_req_ready;
  logic          ls_wen;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic [7:0]    ls_wmask;
  logic [2:0]    ls_rmask;
  logic          ls_resp_valid;
  logic [DW-1:0] ls_rdata;

  logic          m_req_valid;
  logic          m_req_ready;
  logic          m_wen;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [7:0]    m_wmask;
  logic [2:0]    m_rmask;
  logic          m_resp_valid;
  logic [DW-1:0] m_rdata;

  logic          err;

  // Arbiter side
  modport master (
    input  if_req_valid, if_addr,
    input  ls_req_valid, ls_wen, ls_addr, ls_wdata, ls_wmask, ls_rmask,
    input  m_req_ready, m_resp_valid, m_rdata,
    output if_req_ready, if_resp_valid, if_rdata,
    output ls_req_ready, ls_resp_valid, ls_rdata,
    output m_req_valid, m_wen, m_addr, m_wdata, m_wmask, m_rmask,
    output err
  );

  // Requesters and memory side
  modport slave (
    output if_req_valid, if_addr,
    output ls_req_valid, ls_wen, ls_addr, ls_wdata, ls_wmask, ls_rmask,
    output m_req_ready, m_resp_valid, m_rdata,
    input  if_req_ready, if_resp_valid, if_rdata,
    input  ls_req_ready, ls_resp_valid, ls_rdata,
    input  m_req_valid, m_wen, m_addr, m_wdata, m_wmask, m_rmask,
    input  err
  );
endinterface

// File: rtl/mem_port_arbiter_timer.sv
// rtl/mem_port_arbiter_timer.sv - response timeout counter, expires at count TIMEOUT-1
module arb_timeout_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises fetch and load/store requests onto one memory port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TIMEOUT   = 64,
  parameter int LS_STREAK = 4
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);
  localparam int SW = $clog2(LS_STREAK + 1);

  arb_state_e    r_state, w_state_nxt;
  arb_owner_e    r_owner;
  logic [SW-1:0] r_streak;
  logic          r_stale;
  logic          r_m_wen;
  logic [AW-1:0] r_m_addr;
  logic [DW-1:0] r_m_wdata;
  logic [7:0]    r_m_wmask;
  logic [2:0]    r_m_rmask;
  logic          r_if_resp_valid, r_ls_resp_valid, r_err;
  logic [DW-1:0] r_if_rdata, r_ls_rdata;

  logic          w_grant_if, w_grant_ls;
  logic          w_timer_clr, w_timer_en, w_expire;
  logic          w_resp_ok, w_done, w_timeout;
  logic [DW-1:0] w_rdata;

  // A response arriving while stale belongs to an abandoned transaction
  assign w_resp_ok = bus.m_resp_valid && !r_stale;

  arb_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_timer_clr),
    .i_en     (w_timer_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ARB_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_ls  = 1'b0;
    w_timer_clr = 1'b1;
    w_timer_en  = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (bus.ls_req_valid && !(bus.if_req_valid && r_streak == SW'(LS_STREAK)))
          w_grant_ls = 1'b1;
        else if (bus.if_req_valid)
          w_grant_if = 1'b1;
        if (w_grant_ls || w_grant_if) w_state_nxt = ARB_REQ;
      end
      ARB_REQ: begin
        if (bus.m_req_ready) w_state_nxt = ARB_WAIT;
      end
      ARB_WAIT: begin
        w_timer_clr = 1'b0;
        w_timer_en  = 1'b1;
        if (w_resp_ok) begin
          w_done      = 1'b1;
          w_state_nxt = ARB_IDLE;
        end else if (w_expire) begin
          w_timeout   = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner   <= OWN_IF;
      r_streak  <= '0;
      r_m_wen   <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_m_wmask <= '0;
      r_m_rmask <= '0;
    end else if (w_grant_ls) begin
      r_owner   <= OWN_LS;
      r_streak  <= bus.if_req_valid ? r_streak + 1'b1 : '0;
      r_m_wen   <= bus.ls_wen;
      r_m_addr  <= bus.ls_addr;
      r_m_wdata <= bus.ls_wdata;
      r_m_wmask <= bus.ls_wmask;
      r_m_rmask <= bus.ls_rmask;
    end else if (w_grant_if) begin
      r_owner   <= OWN_IF;
      r_streak  <= '0;
      r_m_wen   <= 1'b0;
      r_m_addr  <= bus.if_addr;
      r_m_wdata <= '0;
      r_m_wmask <= '0;
      r_m_rmask <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_stale <= 1'b0;
    else if (w_timeout)  r_stale <= 1'b1;
    else if (bus.m_resp_valid) r_stale <= 1'b0;
  end

  assign w_rdata = w_timeout ? DW'(ARB_ERR_DATA) : (r_m_wen ? '0 : bus.m_rdata);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_resp_valid <= 1'b0;
      r_ls_resp_valid <= 1'b0;
      r_if_rdata      <= '0;
      r_ls_rdata      <= '0;
      r_err           <= 1'b0;
    end else begin
      r_if_resp_valid <= 1'b0;
      r_ls_resp_valid <= 1'b0;
      r_err           <= 1'b0;
      if (w_done || w_timeout) begin
        if (r_owner == OWN_LS) begin
          r_ls_resp_valid <= 1'b1;
          r_ls_rdata      <= w_rdata;
        end else begin
          r_if_resp_valid <= 1'b1;
          r_if_rdata      <= w_rdata;
        end
        r_err <= w_timeout;
      end
    end
  end

  assign bus.if_req_ready  = w_grant_if;
  assign bus.ls_req_ready  = w_grant_ls;
  assign bus.if_resp_valid = r_if_resp_valid;
  assign bus.if_rdata      = r_if_rdata;
  assign bus.ls_resp_valid = r_ls_resp_valid;
  assign bus.ls_rdata      = r_ls_rdata;
  assign bus.m_req_valid   = (r_state == ARB_REQ);
  assign bus.m_wen         = r_m_wen;
  assign bus.m_addr        = r_m_addr;
  assign bus.m_wdata       = r_m_wdata;
  assign bus.m_wmask       = r_m_wmask;
  assign bus.m_rmask       = r_m_rmask;
  assign bus.err           = r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(8), .LS_STREAK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_ls;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  wmask;
    logic [2:0]  rmask;
    int          delay;
    logic [31:0] mem_rdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Handshake in an IDLE cycle, accept in REQ; returns at the first WAIT negedge
  task automatic start_req(input vec_t v, input string tag);
    @(negedge clk);
    if (v.is_ls) begin
      bus.ls_wen       = v.wen;
      bus.ls_addr      = v.addr;
      bus.ls_wdata     = v.wdata;
      bus.ls_wmask     = v.wmask;
      bus.ls_rmask     = v.rmask;
      bus.ls_req_valid = 1'b1;
    end else begin
      bus.if_addr      = v.addr;
      bus.if_req_valid = 1'b1;
    end
    #1;
    chk({tag, "_rdy"},   v.is_ls ? bus.ls_req_ready : bus.if_req_ready, 1);
    chk({tag, "_nordy"}, v.is_ls ? bus.if_req_ready : bus.ls_req_ready, 0);
    @(negedge clk);
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;
    #1;
    chk({tag, "_mvalid"}, bus.m_req_valid, 1);
    chk({tag, "_maddr"},  bus.m_addr, v.addr);
    chk({tag, "_mwen"},   bus.m_wen, v.wen);
    if (v.is_ls) begin
      chk({tag, "_mwdata"}, bus.m_wdata, v.wdata);
      chk({tag, "_mwmask"}, bus.m_wmask, v.wmask);
      chk({tag, "_mrmask"}, bus.m_rmask, v.rmask);
    end
    bus.m_req_ready = 1'b1;
    @(negedge clk);
    bus.m_req_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    start_req(v, tag);
    repeat (v.delay) @(negedge clk);
    bus.m_resp_valid = 1'b1;
    bus.m_rdata      = v.mem_rdata;
    @(negedge clk);
    bus.m_resp_valid = 1'b0;
    bus.m_rdata      = '0;
    #1;
    chk({tag, "_resp"},   v.is_ls ? bus.ls_resp_valid : bus.if_resp_valid, 1);
    chk({tag, "_noresp"}, v.is_ls ? bus.if_resp_valid : bus.ls_resp_valid, 0);
    chk({tag, "_rdata"},  v.is_ls ? bus.ls_rdata : bus.if_rdata, v.exp_rdata);
    chk({tag, "_err"},    bus.err, 0);
    @(negedge clk);
    #1;
    chk({tag, "_pulse"},  v.is_ls ? bus.ls_resp_valid : bus.if_resp_valid, 0);
  endtask

  task automatic timeout_txn(input vec_t v, input string tag);
    int n;
    bit got;
    start_req(v, tag);
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      #1;
      n++;
      got = v.is_ls ? bus.ls_resp_valid : bus.if_resp_valid;
    end
    chk({tag, "_to_lat"},   n, 8);
    chk({tag, "_to_rdata"}, v.is_ls ? bus.ls_rdata : bus.if_rdata, 32'hdeadbeaf);
    chk({tag, "_to_err"},   bus.err, 1);
    chk({tag, "_to_stale"}, dut.r_stale, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal;
  end

  initial begin
    vec_t v;
    int   cnt;
    bit   exp_ls[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    vecs[0] = '{is_ls:0, wen:0, addr:32'h80000000, wdata:0, wmask:0, rmask:0, delay:0,
                mem_rdata:32'h00100093, exp_rdata:32'h00100093};
    vecs[1] = '{is_ls:1, wen:0, addr:32'h80000100, wdata:0, wmask:0, rmask:3'b010, delay:2,
                mem_rdata:32'h11223344, exp_rdata:32'h11223344};
    vecs[2] = '{is_ls:1, wen:1, addr:32'h80001000, wdata:32'hA5A5A5A5, wmask:8'h0F, rmask:0, delay:1,
                mem_rdata:32'hFFFFFFFF, exp_rdata:32'h0};
    vecs[3] = '{is_ls:0, wen:0, addr:32'h80000004, wdata:0, wmask:0, rmask:0, delay:3,
                mem_rdata:32'h00000013, exp_rdata:32'h00000013};
    vecs[4] = '{is_ls:1, wen:0, addr:32'h80000200, wdata:0, wmask:0, rmask:3'b100, delay:5,
                mem_rdata:32'hCAFEF00D, exp_rdata:32'hCAFEF00D};
    // Response lands on the expiry cycle: data must win over the timeout
    vecs[5] = '{is_ls:0, wen:0, addr:32'h80000008, wdata:0, wmask:0, rmask:0, delay:7,
                mem_rdata:32'h00308193, exp_rdata:32'h00308193};

    rst              = 1'b0;
    bus.if_req_valid = 1'b0;
    bus.if_addr      = '0;
    bus.ls_req_valid = 1'b0;
    bus.ls_wen       = 1'b0;
    bus.ls_addr      = '0;
    bus.ls_wdata     = '0;
    bus.ls_wmask     = '0;
    bus.ls_rmask     = '0;
    bus.m_req_ready  = 1'b0;
    bus.m_resp_valid = 1'b0;
    bus.m_rdata      = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mvalid", bus.m_req_valid, 0);
    chk("rst_maddr",  bus.m_addr, 0);
    chk("rst_ifresp", bus.if_resp_valid, 0);
    chk("rst_lsresp", bus.ls_resp_valid, 0);
    chk("rst_err",    bus.err, 0);
    chk("rst_state",  dut.r_state, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    chk("race_stale", dut.r_stale, 0);

    // Contention: both requesters hold valid across ten back-to-back grants
    @(negedge clk);
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'h80000010;
    bus.ls_req_valid = 1'b1;
    bus.ls_wen       = 1'b0;
    bus.ls_addr      = 32'h80000400;
    bus.ls_wdata     = '0;
    bus.ls_wmask     = '0;
    bus.ls_rmask     = 3'b010;
    #1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("cont%0d_lsrdy", k), bus.ls_req_ready, exp_ls[k]);
      chk($sformatf("cont%0d_ifrdy", k), bus.if_req_ready, !exp_ls[k]);
      @(negedge clk);
      #1;
      bus.m_req_ready = 1'b1;
      @(negedge clk);
      bus.m_req_ready  = 1'b0;
      bus.m_resp_valid = 1'b1;
      bus.m_rdata      = 32'h100 + k;
      @(negedge clk);
      bus.m_resp_valid = 1'b0;
      #1;
      chk($sformatf("cont%0d_resp", k),
          exp_ls[k] ? bus.ls_resp_valid : bus.if_resp_valid, 1);
      chk($sformatf("cont%0d_rdata", k),
          exp_ls[k] ? bus.ls_rdata : bus.if_rdata, 32'h100 + k);
    end
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;
    chk("cont_streak", dut.r_streak, 0);

    // Store held in REQ for five cycles while the requester changes its inputs
    @(negedge clk);
    bus.ls_req_valid = 1'b1;
    bus.ls_wen       = 1'b1;
    bus.ls_addr      = 32'h80001000;
    bus.ls_wdata     = 32'hA5A5A5A5;
    bus.ls_wmask     = 8'h0F;
    bus.ls_rmask     = 3'b000;
    #1;
    chk("st_rdy", bus.ls_req_ready, 1);
    @(negedge clk);
    bus.ls_req_valid = 1'b0;
    bus.ls_wen       = 1'b0;
    bus.ls_addr      = '0;
    bus.ls_wdata     = '0;
    bus.ls_wmask     = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("st%0d_mvalid", i), bus.m_req_valid, 1);
      chk($sformatf("st%0d_maddr", i),  bus.m_addr, 32'h80001000);
      chk($sformatf("st%0d_mwdata", i), bus.m_wdata, 32'hA5A5A5A5);
      chk($sformatf("st%0d_mwmask", i), bus.m_wmask, 8'h0F);
      chk($sformatf("st%0d_mwen", i),   bus.m_wen, 1);
      @(negedge clk);
    end
    bus.m_req_ready = 1'b1;
    @(negedge clk);
    bus.m_req_ready = 1'b0;
    @(negedge clk);
    bus.m_resp_valid = 1'b1;
    bus.m_rdata      = 32'h5555AAAA;
    cnt = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      bus.m_resp_valid = 1'b0;
      #1;
      if (bus.ls_resp_valid) begin
        cnt++;
        chk("st_rdata", bus.ls_rdata, 0);
      end
    end
    chk("st_resp_count", cnt, 1);

    // Timeout, then a stray late response is swallowed
    v = vecs[1];
    v.addr = 32'h80002000;
    timeout_txn(v, "to1");
    @(negedge clk);
    bus.m_resp_valid = 1'b1;
    bus.m_rdata      = 32'h12345678;
    @(negedge clk);
    bus.m_resp_valid = 1'b0;
    #1;
    chk("stray_ifresp", bus.if_resp_valid, 0);
    chk("stray_lsresp", bus.ls_resp_valid, 0);
    chk("stray_err",    bus.err, 0);
    chk("stray_stale",  dut.r_stale, 0);
    run_vec(vecs[0], "post_to1");

    // Timeout, then the next fetch's WAIT must skip exactly one response
    v = vecs[3];
    timeout_txn(v, "to2");
    v = vecs[0];
    v.addr = 32'h80000020;
    start_req(v, "stale_fetch");
    bus.m_resp_valid = 1'b1;
    bus.m_rdata      = 32'hBAD0BAD0;
    @(negedge clk);
    bus.m_rdata      = 32'h00200113;
    #1;
    chk("stale_skip", bus.if_resp_valid, 0);
    @(negedge clk);
    bus.m_resp_valid = 1'b0;
    #1;
    chk("stale_resp",  bus.if_resp_valid, 1);
    chk("stale_rdata", bus.if_rdata, 32'h00200113);
    chk("stale_err",   bus.err, 0);

    // Asynchronous reset while waiting on memory
    start_req(vecs[4], "rstw");
    #2;
    rst = 1'b0;
    #1;
    chk("rstw_state",  dut.r_state, 0);
    chk("rstw_mvalid", bus.m_req_valid, 0);
    chk("rstw_maddr",  bus.m_addr, 0);
    chk("rstw_ifdata", bus.if_rdata, 0);
    chk("rstw_lsdata", bus.ls_rdata, 0);
    chk("rstw_err",    bus.err, 0);
    @(negedge clk);
    rst = 1'b1;
    run_vec(vecs[0], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences one shared single-port memory between the instruction-fetch path (IF, driven by pc) and the load/store path (LS, driven by ALU result/src2/masks) as the core moves from single-cycle to multi-cycle operation.
- Owns the memory handshake and serialises requests.
- Returns read data or write acknowledgements to the owning requester.
- Provides bounded-latency error recovery through a response timeout.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 64, cycles allowed in WAIT before an error response (must be ≥2)
- LS_STREAK, 4, maximum consecutive LS grants while IF is pending

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted
- if_addr  in  AW  fetch address
- if_resp_valid  out  1  fetch data valid, single-cycle pulse
- if_rdata  out  DW  fetched instruction
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  load/store request accepted
- ls_wen  in  1  1 = store, 0 = load
- ls_addr  in  AW  data address
- ls_wdata  in  DW  store data
- ls_wmask  in  8  store byte mask
- ls_rmask  in  3  load size/sign code
- ls_resp_valid  out  1  load data or store acknowledge, single-cycle pulse
- ls_rdata  out  DW  load data
- m_req_valid  out  1  memory request
- m_req_ready  in  1  memory accepts request
- m_wen, m_addr, m_wdata, m_wmask, m_rmask  out  1/AW/DW/8/3  registered copy of the granted request
- m_resp_valid  in  1  memory response (read data or write acknowledge)
- m_rdata  in  DW  memory read data
- err  out  1  timeout pulse

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; streak=0; timer=0; stale=0.
- States: IDLE, REQ, WAIT.
- IDLE, arbitration (combinational):
  - LS wins if ls_req_valid, unless if_req_valid && streak==LS_STREAK; in that case IF wins.
  - The winner's *_req_ready=1; the loser's ready=0.
  - Ready is asserted only in IDLE.
  - On handshake: latch request fields and owner into registers; go to REQ.
- Streak counter:
  - LS grant while IF valid: streak+1, saturating.
  - IF grant or LS grant with IF idle: streak=0.
- REQ: m_req_valid=1 with the latched fields, held stable until m_req_ready. On m_req_ready go to WAIT; timer=0.
- WAIT:
  - Timer increments each cycle.
  - On m_resp_valid: register m_rdata into owner rdata; pulse owner resp_valid next cycle; go to IDLE. Stores also wait for m_resp_valid and return rdata=0.
  - If timer reaches TIMEOUT-1 without a response: pulse owner resp_valid with rdata=32'hdeadbeaf and pulse err; set stale=1; go to IDLE.
- Same-cycle m_resp_valid and timeout: the response wins; no err; stale unchanged.
- stale=1: the next m_resp_valid in any state is discarded and clears stale. While stale=1, a new request may still issue, but its WAIT ignores exactly one response.
- Latency: handshake to resp_valid is 3 cycles minimum (IDLE → REQ → WAIT → pulse) with zero-wait memory.
- Back-to-back: a new grant is possible in the IDLE cycle that coincides with the resp_valid pulse.
- Requesters must hold valid and fields stable until ready. The arbiter never drops a granted request.
- Only one transaction is outstanding at a time; no pipelining.
- m_* outputs are driven only from registers, never combinationally from requester inputs.

Decomposition:
- Add to defines.v:
  - state encodings ARB_IDLE/ARB_REQ/ARB_WAIT (2-bit)
  - owner codes OWN_IF/OWN_LS
  - ARB_ERR_DATA = 32'hdeadbeaf
- One sub-module, arb_timeout_timer: counter with clear/enable, outputs expire at TIMEOUT-1, parameterised by TIMEOUT, same clk/rst.

Test Plan:
- Fetch only: if_req_valid, if_addr=0x80000000, memory ready and responds with 0x00100093 after 1 cycle → if_req_ready in cycle 0; m_addr=0x80000000; if_resp_valid with if_rdata=0x00100093 exactly 3 cycles after handshake.
- Contention: IF and LS both valid continuously, LS_STREAK=4 → grant order LS,LS,LS,LS,IF,LS…; streak returns to 0 after the IF grant.
- Store: ls_wen=1, addr=0x80001000, wdata=0xA5A5A5A5, wmask=0x0F; m_req_ready held low 5 cycles → m_* fields stable throughout REQ; ls_resp_valid once after m_resp_valid; rdata=0.
- Timeout: TIMEOUT=8, no m_resp_valid → ls_resp_valid with ls_rdata=0xdeadbeaf and err=1 on the same pulse; stale=1; a later m_resp_valid is ignored and the next fetch completes normally.
- Timeout/response race: m_resp_valid on the expiry cycle → normal data returned; err=0; stale=0.
- Reset mid-WAIT: drive rst=0 asynchronously → all outputs 0 immediately, state IDLE; after release, a fresh fetch completes in 3 cycles.
